idex_stage: RTL
===============

# idex_stage

ID/EX pipeline stage of the MIPS datapath, sitting directly downstream of the instruction decoder. It registers the decoder's control word together with register-file operands, immediate and register specifiers, and presents them to the EX stage. It also contains load-use hazard detection: it inserts a bubble and asserts a stall to the fetch/decode side. It honours an external hold and a branch flush, and counts inserted bubbles for performance monitoring.

## Interface
Parameters:
- `DW`, default 32: datapath width.
- `CNTW`, default 16: bubble counter width.

Ports:
- `clk` in 1: clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `stall_i` in 1: downstream hold; the stage keeps its contents.
- `flush_i` in 1: branch taken; squash the instruction currently in ID.
- `id_valid_i` in 1: ID holds a real instruction.
- `regW_i`, `MemReg_i`, `memWritte_i`, `Branch_i`, `RegD_i` in 1 each: decoder control bits. `RegD_i`=1 selects `rd_i` as destination; 0 selects `rt_i`.
- `AluControl_i` in 4, `AluSrcD_i` in 2, `ShiftD_i` in 4: ALU control.
- `MemReadByte_i`, `MemWriteByte_i` in 4 each: byte-lane masks.
- `rd1_i`, `rd2_i`, `imm_i`, `pc4_i` in DW each: operands, sign-extended immediate, PC+4.
- `rs_i`, `rt_i`, `rd_i`, `shamt_i` in 5 each: register specifiers and shift amount.
- Registered outputs (`_e` suffix, one per input above): `regW_e`, `MemReg_e`, `memWritte_e`, `Branch_e`, `AluControl_e`, `AluSrcD_e`, `ShiftD_e`, `MemReadByte_e`, `MemWriteByte_e`, `rd1_e`, `rd2_e`, `imm_e`, `pc4_e`, `rs_e`, `rt_e`, `shamt_e`.
- `wreg_e` out 5: resolved destination register.
- `valid_e` out 1: EX holds a real instruction.
- `hazard_o` out 1: combinational load-use stall to PC and IF/ID.
- `bubble_cnt_o` out CNTW: saturating count of inserted bubbles.

## Operation
- Bubble word:
  - Control bits (`regW`, `MemReg`, `memWritte`, `Branch`, `RegD`) = 0; `valid` = 0.
  - `AluControl` = ADD (0000), `AluSrcD` = 00, `ShiftD` = 0.
  - `MemReadByte` / `MemWriteByte` = 4'b1111.
  - All data and specifier fields = 0.
- Hazard: `hazard_o` = `valid_e` & `MemReg_e` & `regW_e` & (`wreg_e` != 0) & `id_valid_i` & ((`wreg_e` == `rs_i`) | (`wreg_e` == `rt_i`)).
- Next-state priority, evaluated each rising edge:
  1. `reset` → bubble word; counter cleared.
  2. `flush_i` → load bubble, even if `stall_i` is high; counter not incremented.
  3. `stall_i` → hold all registers; `hazard_o` may stay high; no bubble is counted.
  4. `hazard_o` → load bubble; counter +1, saturating at all-ones.
  5. Otherwise → capture all inputs; `wreg_e` = `RegD_i` ? `rd_i` : `rt_i`; `valid_e` = `id_valid_i`.
- Control bits are forced to 0 whenever `id_valid_i`=0 at capture, so invalid slots never write registers or memory.

## Timing
- All outputs except `hazard_o` are registered, with 1-cycle latency from ID inputs.
- `hazard_o` is combinational from current `_e` state plus `rs_i`/`rt_i`, with no added latency.
- A load-use stall lasts exactly 1 cycle when `stall_i`=0. On the next cycle EX holds the bubble, `hazard_o` drops, and the dependent instruction is captured.
- Reset asserted mid-operation clears the stage immediately (asynchronous). The first capture occurs on the first edge after deassertion.
- The counter holds at 2^CNTW−1 once reached.

## Structure
- Shared defines/package (`mips_defs`):
  - AluControl encodings: ADD 0000, SUB 0001, AND 0010, OR 0011, XOR 0100, NOR 0101, SLL 0110, SRL 0111, SRA 1000, SLT 1001.
  - Bubble-word constant.
  - Full byte-mask constant 4'b1111.
- One sub-module: `hazard_unit` (combinational load-use detect), instantiated inside `idex_stage`.

## Test plan
- Reset while fields hold data → all `_e` outputs = bubble word, `valid_e`=0, `bubble_cnt_o`=0, `hazard_o`=0.
- ADD capture: `RegD_i`=1, `rd_i`=5, `rd1_i`=0x10, `rd2_i`=0x20, `AluControl_i`=0000 → next cycle `wreg_e`=5, `rd1_e`=0x10, `rd2_e`=0x20, `regW_e` follows input, `valid_e`=1.
- Load-use: EX holds LW with `wreg_e`=8; ID has `rs_i`=8 → `hazard_o`=1, next edge loads bubble, `bubble_cnt_o`=1; following edge captures the dependent instruction.
- Load to $0: EX holds LW with `wreg_e`=0; ID has `rs_i`=0 → `hazard_o`=0, no bubble inserted.
- Simultaneous `flush_i`=1, `stall_i`=1 and a hazard → bubble loaded, `bubble_cnt_o` unchanged.
- `stall_i` held 3 cycles with a hazard present → registers unchanged, `hazard_o`=1 throughout, counter unchanged.

Source files
------------

// File: rtl/mips_defs_pkg.sv
// Shared MIPS datapath definitions: ALU opcodes, byte-mask constants and the
// ID/EX control word with its bubble value.
package mips_defs;

  typedef enum logic [3:0] {
    ALU_ADD = 4'b0000,
    ALU_SUB = 4'b0001,
    ALU_AND = 4'b0010,
    ALU_OR  = 4'b0011,
    ALU_XOR = 4'b0100,
    ALU_NOR = 4'b0101,
    ALU_SLL = 4'b0110,
    ALU_SRL = 4'b0111,
    ALU_SRA = 4'b1000,
    ALU_SLT = 4'b1001
  } alu_op_e;

  localparam logic [3:0] BYTE_MASK_ALL = 4'b1111;

  // Control portion of the ID/EX word.
  typedef struct packed {
    logic       regw;
    logic       memreg;
    logic       memwrite;
    logic       branch;
    logic       regd;
    logic [3:0] alu_ctrl;
    logic [1:0] alu_src;
    logic [3:0] shift;
    logic [3:0] mem_rd_byte;
    logic [3:0] mem_wr_byte;
  } ctrl_t;

  // Bubble: nothing written anywhere, ALU does a harmless ADD.
  localparam ctrl_t CTRL_BUBBLE = '{
    regw:        1'b0,
    memreg:      1'b0,
    memwrite:    1'b0,
    branch:      1'b0,
    regd:        1'b0,
    alu_ctrl:    ALU_ADD,
    alu_src:     2'b00,
    shift:       4'b0000,
    mem_rd_byte: BYTE_MASK_ALL,
    mem_wr_byte: BYTE_MASK_ALL
  };

endpackage

// File: rtl/idex_stage_if.sv
// ID/EX bus: decoder-side inputs (_i) and EX-side registered outputs (_e),
// plus hold/flush controls, hazard stall and bubble counter.
//   master: the ID/control side driving _i signals and observing _e signals.
//   slave : the idex_stage itself.
interface idex_stage_if #(
  parameter int DW   = 32,
  parameter int CNTW = 16
);
  logic            stall_i, flush_i, id_valid_i;
  logic            regW_i, MemReg_i, memWritte_i, Branch_i, RegD_i;
  logic [3:0]      AluControl_i;
  logic [1:0]      AluSrcD_i;
  logic [3:0]      ShiftD_i;
  logic [3:0]      MemReadByte_i, MemWriteByte_i;
  logic [DW-1:0]   rd1_i, rd2_i, imm_i, pc4_i;
  logic [4:0]      rs_i, rt_i, rd_i, shamt_i;

  logic            regW_e, MemReg_e, memWritte_e, Branch_e;
  logic [3:0]      AluControl_e;
  logic [1:0]      AluSrcD_e;
  logic [3:0]      ShiftD_e;
  logic [3:0]      MemReadByte_e, MemWriteByte_e;
  logic [DW-1:0]   rd1_e, rd2_e, imm_e, pc4_e;
  logic [4:0]      rs_e, rt_e, shamt_e, wreg_e;
  logic            valid_e;
  logic            hazard_o;
  logic [CNTW-1:0] bubble_cnt_o;

  modport master (
    output stall_i, flush_i, id_valid_i,
    output regW_i, MemReg_i, memWritte_i, Branch_i, RegD_i,
    output AluControl_i, AluSrcD_i, ShiftD_i, MemReadByte_i, MemWriteByte_i,
    output rd1_i, rd2_i, imm_i, pc4_i, rs_i, rt_i, rd_i, shamt_i,
    input  regW_e, MemReg_e, memWritte_e, Branch_e,
    input  AluControl_e, AluSrcD_e, ShiftD_e, MemReadByte_e, MemWriteByte_e,
    input  rd1_e, rd2_e, imm_e, pc4_e, rs_e, rt_e, shamt_e, wreg_e,
    input  valid_e, hazard_o, bubble_cnt_o
  );

  modport slave (
    input  stall_i, flush_i, id_valid_i,
    input  regW_i, MemReg_i, memWritte_i, Branch_i, RegD_i,
    input  AluControl_i, AluSrcD_i, ShiftD_i, MemReadByte_i, MemWriteByte_i,
    input  rd1_i, rd2_i, imm_i, pc4_i, rs_i, rt_i, rd_i, shamt_i,
    output regW_e, MemReg_e, memWritte_e, Branch_e,
    output AluControl_e, AluSrcD_e, ShiftD_e, MemReadByte_e, MemWriteByte_e,
    output rd1_e, rd2_e, imm_e, pc4_e, rs_e, rt_e, shamt_e, wreg_e,
    output valid_e, hazard_o, bubble_cnt_o
  );
endinterface

// File: rtl/idex_stage_hazard.sv
// hazard_unit: combinational load-use detector.
//   Inputs : EX-side valid/MemReg/regW/wreg, ID-side valid and rs/rt.
//   Output : hazard_o, high when the load in EX feeds the instruction in ID.
module hazard_unit (
  input  logic       valid_e,
  input  logic       memreg_e,
  input  logic       regw_e,
  input  logic [4:0] wreg_e,
  input  logic       id_valid_i,
  input  logic [4:0] rs_i,
  input  logic [4:0] rt_i,
  output logic       hazard_o
);
  // $0 is hard-wired, so a load targeting it never creates a dependency.
  assign hazard_o = valid_e & memreg_e & regw_e & (wreg_e != 5'd0) & id_valid_i
                  & ((wreg_e == rs_i) | (wreg_e == rt_i));
endmodule

// File: rtl/idex_stage.sv
// idex_stage: ID/EX pipeline register with load-use bubble insertion.
//   clk, reset : rising-edge clock, asynchronous active-high reset.
//   bus        : idex_stage_if.slave carrying decoder inputs, EX outputs,
//                stall/flush controls, hazard_o and bubble_cnt_o.
// Update priority each edge: flush > stall (hold) > hazard (bubble) > capture.
module idex_stage
  import mips_defs::*;
#(
  parameter int DW   = 32,
  parameter int CNTW = 16
) (
  input logic        clk,
  input logic        reset,
  idex_stage_if.slave bus
);

  ctrl_t           ctrl_q, ctrl_d;
  logic            valid_q, valid_d;
  logic [DW-1:0]   rd1_q, rd1_d, rd2_q, rd2_d, imm_q, imm_d, pc4_q, pc4_d;
  logic [4:0]      rs_q, rs_d, rt_q, rt_d, shamt_q, shamt_d, wreg_q, wreg_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic            hazard;

  hazard_unit u_hazard (
    .valid_e    (valid_q),
    .memreg_e   (ctrl_q.memreg),
    .regw_e     (ctrl_q.regw),
    .wreg_e     (wreg_q),
    .id_valid_i (bus.id_valid_i),
    .rs_i       (bus.rs_i),
    .rt_i       (bus.rt_i),
    .hazard_o   (hazard)
  );

  always_comb begin
    ctrl_d  = ctrl_q;
    valid_d = valid_q;
    rd1_d   = rd1_q;
    rd2_d   = rd2_q;
    imm_d   = imm_q;
    pc4_d   = pc4_q;
    rs_d    = rs_q;
    rt_d    = rt_q;
    shamt_d = shamt_q;
    wreg_d  = wreg_q;
    cnt_d   = cnt_q;

    if (bus.flush_i || (!bus.stall_i && hazard)) begin
      ctrl_d  = CTRL_BUBBLE;
      valid_d = 1'b0;
      rd1_d   = '0;
      rd2_d   = '0;
      imm_d   = '0;
      pc4_d   = '0;
      rs_d    = '0;
      rt_d    = '0;
      shamt_d = '0;
      wreg_d  = '0;
      // Only hazard bubbles are counted; flush squashes are not.
      if (!bus.flush_i && (cnt_q != {CNTW{1'b1}}))
        cnt_d = cnt_q + CNTW'(1);
    end else if (!bus.stall_i) begin
      // Invalid slots keep their data but can never write anything.
      ctrl_d.regw        = bus.regW_i      & bus.id_valid_i;
      ctrl_d.memreg      = bus.MemReg_i    & bus.id_valid_i;
      ctrl_d.memwrite    = bus.memWritte_i & bus.id_valid_i;
      ctrl_d.branch      = bus.Branch_i    & bus.id_valid_i;
      ctrl_d.regd        = bus.RegD_i      & bus.id_valid_i;
      ctrl_d.alu_ctrl    = bus.AluControl_i;
      ctrl_d.alu_src     = bus.AluSrcD_i;
      ctrl_d.shift       = bus.ShiftD_i;
      ctrl_d.mem_rd_byte = bus.MemReadByte_i;
      ctrl_d.mem_wr_byte = bus.MemWriteByte_i;
      valid_d = bus.id_valid_i;
      rd1_d   = bus.rd1_i;
      rd2_d   = bus.rd2_i;
      imm_d   = bus.imm_i;
      pc4_d   = bus.pc4_i;
      rs_d    = bus.rs_i;
      rt_d    = bus.rt_i;
      shamt_d = bus.shamt_i;
      wreg_d  = bus.RegD_i ? bus.rd_i : bus.rt_i;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl_q  <= CTRL_BUBBLE;
      valid_q <= 1'b0;
      rd1_q   <= '0;
      rd2_q   <= '0;
      imm_q   <= '0;
      pc4_q   <= '0;
      rs_q    <= '0;
      rt_q    <= '0;
      shamt_q <= '0;
      wreg_q  <= '0;
      cnt_q   <= '0;
    end else begin
      ctrl_q  <= ctrl_d;
      valid_q <= valid_d;
      rd1_q   <= rd1_d;
      rd2_q   <= rd2_d;
      imm_q   <= imm_d;
      pc4_q   <= pc4_d;
      rs_q    <= rs_d;
      rt_q    <= rt_d;
      shamt_q <= shamt_d;
      wreg_q  <= wreg_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.regW_e         = ctrl_q.regw;
  assign bus.MemReg_e       = ctrl_q.memreg;
  assign bus.memWritte_e    = ctrl_q.memwrite;
  assign bus.Branch_e       = ctrl_q.branch;
  assign bus.AluControl_e   = ctrl_q.alu_ctrl;
  assign bus.AluSrcD_e      = ctrl_q.alu_src;
  assign bus.ShiftD_e       = ctrl_q.shift;
  assign bus.MemReadByte_e  = ctrl_q.mem_rd_byte;
  assign bus.MemWriteByte_e = ctrl_q.mem_wr_byte;
  assign bus.rd1_e          = rd1_q;
  assign bus.rd2_e          = rd2_q;
  assign bus.imm_e          = imm_q;
  assign bus.pc4_e          = pc4_q;
  assign bus.rs_e           = rs_q;
  assign bus.rt_e           = rt_q;
  assign bus.shamt_e        = shamt_q;
  assign bus.wreg_e         = wreg_q;
  assign bus.valid_e        = valid_q;
  assign bus.hazard_o       = hazard;
  assign bus.bubble_cnt_o   = cnt_q;

endmodule
